// File: rtl/observer_sched_pkg.sv
// Shared types for the observer notification scheduler: command opcodes,
// observer kinds, dispatch FSM states and the observer table entry.
package observer_sched_pkg;

  localparam int unsigned OBS_DATA_W = 32;

  typedef enum logic [1:0] {
    ADD_DISPLAY = 2'd0,
    ADD_ALARM   = 2'd1,
    REMOVE      = 2'd2,
    SET_TEMP    = 2'd3
  } cmd_op_e;

  typedef enum logic {
    DISPLAY = 1'b0,
    ALARM   = 1'b1
  } obs_kind_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    NOTIFY = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  // id_or_thresh holds the display ID or the alarm threshold
  typedef struct packed {
    logic                  valid;
    obs_kind_e             kind;
    logic [OBS_DATA_W-1:0] id_or_thresh;
  } obs_entry_t;

endpackage

// File: rtl/observer_notify_scheduler_if.sv
// Command, notification and status signals of the observer scheduler.
// master = command source / notification sink, slave = scheduler.
interface observer_notify_scheduler_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OBS = 4
);
  localparam int unsigned CNT_W = $clog2(MAX_OBS + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_arg;
  logic              cmd_err;
  logic              notify_valid;
  logic              notify_ready;
  logic [DATA_W-1:0] notify_id;
  logic              notify_kind;
  logic [DATA_W-1:0] notify_temp;
  logic              notify_alarm;
  logic              dispatch_done;
  logic              alarm_active;
  logic [CNT_W-1:0]  obs_count;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, notify_ready,
    input  cmd_ready, cmd_err, notify_valid, notify_id, notify_kind,
           notify_temp, notify_alarm, dispatch_done, alarm_active, obs_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, notify_ready,
    output cmd_ready, cmd_err, notify_valid, notify_id, notify_kind,
           notify_temp, notify_alarm, dispatch_done, alarm_active, obs_count
  );

endinterface

// File: rtl/observer_notify_scheduler_table.sv
// Observer slot storage with lowest-free-slot search, ID match for
// removal/duplicate detection, and a registered occupancy count.
module observer_table
  import observer_sched_pkg::*;
#(
  parameter int unsigned       MAX_OBS       = 4,
  parameter int unsigned       DATA_W        = OBS_DATA_W,
  parameter logic [DATA_W-1:0] ALARM_ID_BASE = 32'hA1A0,
  localparam int unsigned      IDX_W         = $clog2(MAX_OBS),
  localparam int unsigned      CNT_W         = $clog2(MAX_OBS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_i,
  input  logic              rm_i,
  input  obs_kind_e         kind_i,
  input  logic [DATA_W-1:0] arg_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output obs_entry_t        rd_entry_o,
  output logic              full_o,
  output logic              dup_o,
  output logic              match_o,
  output logic [CNT_W-1:0]  obs_count_o
);

  obs_entry_t       slots_q [MAX_OBS];
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] match_idx;
  logic             free_found;
  logic             match_found;
  logic             dup_found;

  // Descending scan so the lowest free slot wins
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    dup_found   = 1'b0;
    for (int i = int'(MAX_OBS) - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(MAX_OBS); i++) begin
      if (slots_q[i].valid) begin
        if (slots_q[i].kind == DISPLAY && slots_q[i].id_or_thresh == arg_i) begin
          dup_found   = 1'b1;
          match_found = 1'b1;
          match_idx   = IDX_W'(i);
        end
        if (slots_q[i].kind == ALARM && (ALARM_ID_BASE + DATA_W'(i)) == arg_i) begin
          match_found = 1'b1;
          match_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_OBS); i++) slots_q[i] <= '0;
      count_q <= '0;
    end else if (add_i) begin
      slots_q[free_idx] <= '{valid: 1'b1, kind: kind_i, id_or_thresh: arg_i};
      count_q           <= count_q + CNT_W'(1);
    end else if (rm_i) begin
      slots_q[match_idx].valid <= 1'b0;
      count_q                  <= count_q - CNT_W'(1);
    end
  end

  assign rd_entry_o  = slots_q[rd_idx_i];
  assign full_o      = !free_found;
  assign dup_o       = dup_found;
  assign match_o     = match_found;
  assign obs_count_o = count_q;

endmodule

// File: rtl/observer_notify_scheduler.sv
// Observer notification scheduler: command handling, temperature latch and
// per-slot dispatch FSM. Define NOTIFY_ON_CHANGE_EN to skip repeated temps.
module observer_notify_scheduler
  import observer_sched_pkg::*;
#(
  parameter int unsigned       MAX_OBS       = 4,
  parameter int unsigned       DATA_W        = OBS_DATA_W,
  parameter logic [DATA_W-1:0] ALARM_ID_BASE = 32'hA1A0
) (
  input logic                        clk,
  input logic                        rst,
  observer_notify_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(MAX_OBS);
  localparam int unsigned CNT_W = $clog2(MAX_OBS + 1);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] temp_q, temp_d;
  logic              acc_q, acc_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_err_q, cmd_err_d;
  logic              notify_valid_q, notify_valid_d;
  logic [DATA_W-1:0] notify_id_q, notify_id_d;
  logic              notify_kind_q, notify_kind_d;
  logic              notify_alarm_q, notify_alarm_d;
  logic              done_q, done_d;
  logic              alarm_active_q, alarm_active_d;
`ifdef NOTIFY_ON_CHANGE_EN
  logic              seen_q, seen_d;
`endif

  cmd_op_e           op_c;
  obs_entry_t        cur_entry;
  logic              tbl_add, tbl_rm, tbl_full, tbl_dup, tbl_match;
  logic [CNT_W-1:0]  tbl_count;

  assign op_c = cmd_op_e'(bus.cmd_op);

  observer_table #(
    .MAX_OBS      (MAX_OBS),
    .DATA_W       (DATA_W),
    .ALARM_ID_BASE(ALARM_ID_BASE)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .add_i      (tbl_add),
    .rm_i       (tbl_rm),
    .kind_i     ((op_c == ADD_ALARM) ? ALARM : DISPLAY),
    .arg_i      (bus.cmd_arg),
    .rd_idx_i   (idx_q),
    .rd_entry_o (cur_entry),
    .full_o     (tbl_full),
    .dup_o      (tbl_dup),
    .match_o    (tbl_match),
    .obs_count_o(tbl_count)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    temp_d         = temp_q;
    acc_d          = acc_q;
    cmd_err_d      = 1'b0;
    notify_valid_d = notify_valid_q;
    notify_id_d    = notify_id_q;
    notify_kind_d  = notify_kind_q;
    notify_alarm_d = notify_alarm_q;
    alarm_active_d = alarm_active_q;
    tbl_add        = 1'b0;
    tbl_rm         = 1'b0;
`ifdef NOTIFY_ON_CHANGE_EN
    seen_d         = seen_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (op_c)
            ADD_DISPLAY, ADD_ALARM: begin
              if (tbl_full || (op_c == ADD_DISPLAY && tbl_dup)) cmd_err_d = 1'b1;
              else                                              tbl_add   = 1'b1;
            end
            REMOVE: begin
              if (tbl_match) tbl_rm    = 1'b1;
              else           cmd_err_d = 1'b1;
            end
            SET_TEMP: begin
              temp_d = bus.cmd_arg;
              acc_d  = 1'b0;
              idx_d  = '0;
`ifdef NOTIFY_ON_CHANGE_EN
              seen_d = 1'b1;
              if (seen_q && bus.cmd_arg == temp_q) state_d = DONE;
              else                                 state_d = SCAN;
`else
              state_d = SCAN;
`endif
            end
            default: ;
          endcase
        end
      end
      SCAN: begin
        if (cur_entry.valid) begin
          state_d        = NOTIFY;
          notify_valid_d = 1'b1;
          notify_kind_d  = cur_entry.kind;
          notify_id_d    = (cur_entry.kind == DISPLAY) ? cur_entry.id_or_thresh
                                                       : ALARM_ID_BASE + DATA_W'(idx_q);
          notify_alarm_d = (cur_entry.kind == ALARM) && (temp_q > cur_entry.id_or_thresh);
          acc_d          = acc_q | notify_alarm_d;
        end else if (idx_q == IDX_W'(MAX_OBS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      NOTIFY: begin
        if (bus.notify_ready) begin
          notify_valid_d = 1'b0;
          if (idx_q == IDX_W'(MAX_OBS - 1)) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    done_d      = (state_d == DONE);
    // A skipped dispatch enters DONE straight from IDLE and keeps the old alarm state
    if (state_d == DONE && state_q != IDLE) alarm_active_d = acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      temp_q         <= '0;
      acc_q          <= 1'b0;
      cmd_ready_q    <= 1'b1;
      cmd_err_q      <= 1'b0;
      notify_valid_q <= 1'b0;
      notify_id_q    <= '0;
      notify_kind_q  <= 1'b0;
      notify_alarm_q <= 1'b0;
      done_q         <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      temp_q         <= temp_d;
      acc_q          <= acc_d;
      cmd_ready_q    <= cmd_ready_d;
      cmd_err_q      <= cmd_err_d;
      notify_valid_q <= notify_valid_d;
      notify_id_q    <= notify_id_d;
      notify_kind_q  <= notify_kind_d;
      notify_alarm_q <= notify_alarm_d;
      done_q         <= done_d;
      alarm_active_q <= alarm_active_d;
    end
  end

`ifdef NOTIFY_ON_CHANGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seen_q <= 1'b0;
    else     seen_q <= seen_d;
  end
`endif

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.cmd_err       = cmd_err_q;
  assign bus.notify_valid  = notify_valid_q;
  assign bus.notify_id     = notify_id_q;
  assign bus.notify_kind   = notify_kind_q;
  assign bus.notify_temp   = temp_q;
  assign bus.notify_alarm  = notify_alarm_q;
  assign bus.dispatch_done = done_q;
  assign bus.alarm_active  = alarm_active_q;
  assign bus.obs_count     = tbl_count;

endmodule

// File: tb/tb_observer_notify_scheduler.sv
// Randomised bench for observer_notify_scheduler against an array-based
// reference model of the observer table and dispatch timing.
module tb_observer_notify_scheduler;

  localparam int unsigned MAX_OBS    = 4;
  localparam int unsigned DATA_W     = 32;
  localparam logic [31:0] ALARM_BASE = 32'hA1A0;
  localparam int OP_DISP = 0, OP_ALARM = 1, OP_REM = 2, OP_TEMP = 3;

  logic clk = 1'b0;
  logic rst;

  observer_notify_scheduler_if #(.DATA_W(DATA_W), .MAX_OBS(MAX_OBS)) bus ();

  observer_notify_scheduler #(
    .MAX_OBS      (MAX_OBS),
    .DATA_W       (DATA_W),
    .ALARM_ID_BASE(ALARM_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_valid [MAX_OBS];
  bit          m_is_alarm [MAX_OBS];
  logic [31:0] m_val [MAX_OBS];
  logic [31:0] m_temp;
  bit          m_seen;
  bit          m_alarm_active;
  int          m_count;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < int'(MAX_OBS); s++) begin
      m_valid[s] = 1'b0; m_is_alarm[s] = 1'b0; m_val[s] = '0;
    end
    m_temp = '0; m_seen = 1'b0; m_alarm_active = 1'b0; m_count = 0;
  endtask

  // ADD_DISPLAY / ADD_ALARM / REMOVE with model update and result checks
  task automatic do_cmd(input int op, input logic [31:0] arg);
    bit exp_err;
    int free, hit;
    exp_err = 1'b0;
    if (op == OP_REM) begin
      hit = -1;
      for (int s = 0; s < int'(MAX_OBS); s++)
        if (m_valid[s] && ((!m_is_alarm[s] && m_val[s] == arg) ||
                           (m_is_alarm[s] && ALARM_BASE + 32'(s) == arg))) hit = s;
      if (hit < 0) exp_err = 1'b1;
      else begin m_valid[hit] = 1'b0; m_count--; end
    end else begin
      free = -1;
      for (int s = int'(MAX_OBS) - 1; s >= 0; s--) if (!m_valid[s]) free = s;
      for (int s = 0; s < int'(MAX_OBS); s++)
        if (op == OP_DISP && m_valid[s] && !m_is_alarm[s] && m_val[s] == arg) exp_err = 1'b1;
      if (free < 0) exp_err = 1'b1;
      if (!exp_err) begin
        m_valid[free] = 1'b1; m_is_alarm[free] = (op == OP_ALARM); m_val[free] = arg; m_count++;
      end
    end
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'(op); bus.cmd_arg = arg;
    tick();
    bus.cmd_valid = 1'b0;
    check("cmd_err", 32'(bus.cmd_err), 32'(exp_err));
    check("obs_count", 32'(bus.obs_count), 32'(m_count));
    check("cmd_ready_stay", 32'(bus.cmd_ready), 32'd1);
    tick();
    check("cmd_err_pulse", 32'(bus.cmd_err), 32'd0);
  endtask

  // SET_TEMP and follow the whole dispatch; stall < 0 picks random stalls per beat
  task automatic set_temp(input logic [31:0] t, input int stall);
    int exp_slots[$];
    bit skip, in_beat, done_seen, exp_al, alarm_or;
    int cyc, prior, beat, stall_left, s;
    logic [31:0] h_id, h_temp, exp_id;
    logic h_kind, h_alarm;
    skip = 1'b0;
`ifdef NOTIFY_ON_CHANGE_EN
    skip = m_seen && (t == m_temp);
`endif
    m_seen = 1'b1; m_temp = t;
    if (!skip) for (int i = 0; i < int'(MAX_OBS); i++) if (m_valid[i]) exp_slots.push_back(i);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'(OP_TEMP); bus.cmd_arg = t;
    tick();
    bus.cmd_valid = 1'b0;
    cyc = 1; prior = 0; beat = 0; in_beat = 0; done_seen = 0; alarm_or = 0; stall_left = 0;
    h_id = '0; h_temp = '0; h_kind = 1'b0; h_alarm = 1'b0;
    while (cyc <= 200 && !done_seen) begin
      check("busy_ready", 32'(bus.cmd_ready), 32'd0);
      if (bus.notify_valid) begin
        if (!in_beat) begin
          if (beat >= exp_slots.size()) begin
            check("extra_beat", 32'd1, 32'd0);
          end else begin
            s = exp_slots[beat];
            exp_id = m_is_alarm[s] ? ALARM_BASE + 32'(s) : m_val[s];
            exp_al = m_is_alarm[s] && (t > m_val[s]);
            alarm_or |= exp_al;
            check("beat_start", 32'(cyc), 32'(2 + s + prior));
            check("notify_id", bus.notify_id, exp_id);
            check("notify_kind", 32'(bus.notify_kind), 32'(m_is_alarm[s]));
            check("notify_alarm", 32'(bus.notify_alarm), 32'(exp_al));
            check("notify_temp", bus.notify_temp, t);
          end
          in_beat = 1'b1;
          stall_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
          prior += stall_left + 1;
          beat++;
          h_id = bus.notify_id; h_kind = bus.notify_kind;
          h_alarm = bus.notify_alarm; h_temp = bus.notify_temp;
        end else begin
          check("stall_id", bus.notify_id, h_id);
          check("stall_kind", 32'(bus.notify_kind), 32'(h_kind));
          check("stall_alarm", 32'(bus.notify_alarm), 32'(h_alarm));
          check("stall_temp", bus.notify_temp, h_temp);
        end
        bus.notify_ready = (stall_left == 0);
        if (stall_left == 0) in_beat = 1'b0;
        else stall_left--;
      end else begin
        if (in_beat) begin
          check("valid_dropped", 32'd0, 32'd1);
          in_beat = 1'b0;
        end
        bus.notify_ready = 1'($urandom_range(0, 1));
      end
      if (bus.dispatch_done) begin
        done_seen = 1'b1;
        check("done_cycle", 32'(cyc), skip ? 32'd1 : 32'(1 + int'(MAX_OBS) + prior));
        check("beat_count", 32'(beat), 32'(exp_slots.size()));
        if (!skip) m_alarm_active = alarm_or;
        check("alarm_active", 32'(bus.alarm_active), 32'(m_alarm_active));
      end else begin
        check("alarm_hold", 32'(bus.alarm_active), 32'(m_alarm_active));
        cyc++;
        tick();
      end
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    bus.notify_ready = 1'b0;
    tick();
    check("done_pulse", 32'(bus.dispatch_done), 32'd0);
    check("ready_back", 32'(bus.cmd_ready), 32'd1);
    check("alarm_after", 32'(bus.alarm_active), 32'(m_alarm_active));
  endtask

  task automatic reset_mid_dispatch();
    int waited;
    if (m_count == 0) do_cmd(OP_ALARM, 32'd5);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'(OP_TEMP); bus.cmd_arg = 32'd77;
    tick();
    bus.cmd_valid = 1'b0; bus.notify_ready = 1'b0;
    waited = 0;
    while (!bus.notify_valid && waited < 20) begin tick(); waited++; end
    check("stall_reached", 32'(bus.notify_valid), 32'd1);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rst_notify_valid", 32'(bus.notify_valid), 32'd0);
    check("rst_obs_count", 32'(bus.obs_count), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_alarm_active", 32'(bus.alarm_active), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rst_no_done", 32'(bus.dispatch_done), 32'd0);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = '0; bus.notify_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_notify_valid", 32'(bus.notify_valid), 32'd0);
    check("rst_notify_id", bus.notify_id, 32'd0);
    check("rst_notify_temp", bus.notify_temp, 32'd0);
    check("rst_done", 32'(bus.dispatch_done), 32'd0);
    check("rst_alarm", 32'(bus.alarm_active), 32'd0);
    check("rst_count", 32'(bus.obs_count), 32'd0);
    rst = 1'b0;
    tick();

    do_cmd(OP_DISP, 32'd1);
    do_cmd(OP_DISP, 32'd2);
    do_cmd(OP_ALARM, 32'd25);
    set_temp(32'd20, 0);
    set_temp(32'd30, 3);
    set_temp(32'd22, 0);
    set_temp(32'd25, 1);
    do_cmd(OP_REM, 32'd2);
    set_temp(32'd28, 0);
    do_cmd(OP_REM, 32'd99);
    do_cmd(OP_DISP, 32'd5);
    do_cmd(OP_ALARM, 32'd10);
    do_cmd(OP_DISP, 32'd7);
    do_cmd(OP_REM, ALARM_BASE + 32'd3);
    do_cmd(OP_DISP, 32'd1);
    do_cmd(OP_REM, 32'd1);
    do_cmd(OP_REM, 32'd5);
    do_cmd(OP_REM, ALARM_BASE + 32'd2);
    set_temp(32'd40, 0);
    do_cmd(OP_ALARM, 32'd10);
    set_temp(32'd30, 0);
    set_temp(32'd30, 0);

    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 2)      do_cmd(OP_DISP, 32'($urandom_range(1, 8)));
      else if (r <= 4) do_cmd(OP_ALARM, 32'($urandom_range(0, 60)));
      else if (r <= 6) do_cmd(OP_REM, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 8))
                                                                   : ALARM_BASE + 32'($urandom_range(0, 4)));
      else if (r == 7) set_temp(m_temp, -1);
      else             set_temp(32'($urandom_range(0, 60)), -1);
    end

    reset_mid_dispatch();
    do_cmd(OP_DISP, 32'd4);
    set_temp(32'd0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
